score_scan_driver: RTL
======================

SCORE_SCAN_DRIVER -- requirements
Module: score_scan_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles each digit is held on the display (legal ≥ 2).
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: inc  input  1  score increment request, sampled each rising edge.
REQ-005 Port: clr  input  1  synchronous score clear, sampled each rising edge.
REQ-006 Port: digit  output  4  BCD digit (0-9) or blank code 4'hF, fed to the seven-segment decoder.
REQ-007 Port: an  output  4  digit anode enables, active-low, an[0] = least significant digit.
REQ-008 Port: sat  output  1  high while score is saturated at 9999.

Function
REQ-009 Score SHALL be held as four registered BCD digits d3..d0, each always in 0-9.
REQ-010 inc high at an edge (clr low, score < 9999) SHALL add 1 to the score: d0 increments, a digit at 9 wraps to 0 and carries into the next digit.
REQ-011 inc at score 9999 SHALL leave the score unchanged (saturate, no wrap to 0000).
REQ-012 clr high at an edge SHALL set all digits to 0 and SHALL take priority over a simultaneous inc.
REQ-013 inc held high for N consecutive edges SHALL add N; no edge detection is done.
REQ-014 Refresh counter SHALL count 0 to REFRESH_DIV-1 and then wrap to 0.
REQ-015 2-bit scan index SHALL advance 0→1→2→3→0 on the edge where the refresh counter wraps.
REQ-016 an SHALL equal the bitwise inverse of (1 << scan index): exactly one bit low at all times.
REQ-017 digit SHALL equal d[scan index], subject to REQ-024.
REQ-018 digit, an and sat SHALL be combinational decodes of registered state only, and SHALL change only after a clock edge or reset.
REQ-019 A score update and a scan advance on the same edge SHALL both take effect; digit then shows the new score at the new index.
REQ-020 sat SHALL be high if and only if the registered score is 9999.

Reset
REQ-021 Asserting rst SHALL immediately clear the score, refresh counter and scan index, regardless of clk.
REQ-022 While rst is high: digit = 4'h0, an = 4'b1110, sat = 0.
REQ-023 After rst deasserts, the first scan advance SHALL occur on the REFRESH_DIV-th rising edge; inc/clr SHALL be honoured from the first edge.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN, when defined, enables leading-zero blanking: for scan index i ≥ 1, digit SHALL be 4'hF when d[i] and every higher digit are 0. Digit 0 is never blanked, and an is unaffected.
REQ-025 With LEADING_ZERO_BLANK_EN undefined, digit SHALL always be d[scan index]; 4'hF SHALL never be output.

Verification
REQ-026 Reset: assert rst mid-scan with score 0042 → digit=0, an=1110, sat=0 at once, with no clk edge needed.
REQ-027 Scan (REFRESH_DIV=4): no inc → an cycles 1110,1101,1011,0111,1110, each value held exactly 4 cycles.
REQ-028 Count: 12 single-cycle inc pulses → scanned digits 2,1,0,0 (macro off) or 2,1,F,F (macro on).
REQ-029 Saturate: 10000 inc cycles from 0 → score 9999, sat=1 after 9999th; further inc → still 9999, no wrap.
REQ-030 Carry: preload 0999 via 999 incs, then one inc → 1000; with macro on, digits show 0,0,0,1 (middle zeros not blanked).
REQ-031 Priority: inc and clr high on the same edge with score 0057 → score 0000, sat=0.

Source files
------------

// File: rtl/score_scan_driver.sv
// Four-digit BCD score counter with a multiplexed seven-segment scan driver.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module score_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic [3:0] an,
  output logic       sat
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [3:0][3:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0] refreshCnt_q, refreshCnt_d;
  logic [1:0]       scanIdx_q, scanIdx_d;
  logic             atMax;
  logic             carry;
  logic             refreshWrap;

  assign atMax = (bcd_q[3] == 4'd9) && (bcd_q[2] == 4'd9) &&
                 (bcd_q[1] == 4'd9) && (bcd_q[0] == 4'd9);

  // Ripple the +1 through the digits; clear wins, and 9999 holds instead of wrapping.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    if (clr) begin
      bcd_d = '0;
    end else if (inc && !atMax) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (bcd_q[i] == 4'd9) begin
            bcd_d[i] = 4'd0;
          end else begin
            bcd_d[i] = bcd_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
    end
  end

  assign refreshWrap = (refreshCnt_q == CNT_LAST);

  always_comb begin
    refreshCnt_d = refreshCnt_q + CNT_W'(1);
    scanIdx_d    = scanIdx_q;
    if (refreshWrap) begin
      refreshCnt_d = '0;
      scanIdx_d    = scanIdx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q        <= '0;
      refreshCnt_q <= '0;
      scanIdx_q    <= '0;
    end else begin
      bcd_q        <= bcd_d;
      refreshCnt_q <= refreshCnt_d;
      scanIdx_q    <= scanIdx_d;
    end
  end

  assign an  = ~(4'b0001 << scanIdx_q);
  assign sat = atMax;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only when it and every more significant digit are zero.
  logic zero3, zero32, zero321;

  assign zero3   = (bcd_q[3] == 4'd0);
  assign zero32  = zero3 && (bcd_q[2] == 4'd0);
  assign zero321 = zero32 && (bcd_q[1] == 4'd0);

  always_comb begin
    digit = bcd_q[scanIdx_q];
    case (scanIdx_q)
      2'd1:    if (zero321) digit = 4'hF;
      2'd2:    if (zero32)  digit = 4'hF;
      2'd3:    if (zero3)   digit = 4'hF;
      default: digit = bcd_q[0];
    endcase
  end
`else
  assign digit = bcd_q[scanIdx_q];
`endif

endmodule
